// File: rtl/seal_verifier.sv
// Seal-record verifier: loads a 3-word sealed record, replays sensor_id/value/mono
// through the shared CRC16 engine, then checks CRC match, strictly increasing
// mono and session consistency against the anti-replay history.
module seal_verifier (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  crc_byte,
  output logic        crc_feed,
  input  logic        crc_busy,
  input  logic [15:0] crc_value,
  output logic        crc_init,
  input  logic        rec_wr,
  input  logic [31:0] rec_in,
  input  logic        ctrl_wr,
  input  logic [8:0]  ctrl_in,
  output logic [31:0] status_out,
  output logic [31:0] last_mono_out
);

  typedef enum logic [1:0] {StIdle, StFeed, StCheck} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wr_seq_q, wr_seq_d;
  logic        rec_full_q, rec_full_d;
  logic [31:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
  logic [7:0]  sid_q, sid_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic        wait_q, wait_d;
  logic        done_q, done_d;
  logic        dropped_q, dropped_d;
  logic        fmt_err_q, fmt_err_d;
  logic        sess_ok_q, sess_ok_d;
  logic        mono_ok_q, mono_ok_d;
  logic        crc_ok_q, crc_ok_d;
  logic        pass_q, pass_d;
  logic        hist_q, hist_d;
  logic [31:0] last_mono_q, last_mono_d;
  logic [7:0]  locked_sid_q, locked_sid_d;

  // Record field views
  logic [7:0]  rec_sid;
  logic [31:0] rec_mono;
  logic [15:0] rec_crc;
  logic [7:0]  rec_pad;
  logic        chk_crc, chk_mono, chk_sess;
  logic        busy;

  assign rec_sid  = w1_q[31:24];
  assign rec_mono = {w2_q[31:24], w1_q[23:0]};
  assign rec_crc  = w2_q[23:8];
  assign rec_pad  = w2_q[7:0];

  assign chk_crc  = (crc_value == rec_crc);
  assign chk_mono = !hist_q || (rec_mono > last_mono_q);
  assign chk_sess = !hist_q || (rec_sid == locked_sid_q);

  assign busy          = (state_q != StIdle);
  assign status_out    = {23'b0, done_q, dropped_q, fmt_err_q, sess_ok_q, mono_ok_q,
                          crc_ok_q, pass_q, ~busy, busy};
  assign last_mono_out = last_mono_q;

  // Next-state, record load, CRC handshake and verdict logic
  always_comb begin
    state_d      = state_q;
    wr_seq_d     = wr_seq_q;
    rec_full_d   = rec_full_q;
    w0_d         = w0_q;
    w1_d         = w1_q;
    w2_d         = w2_q;
    sid_d        = sid_q;
    byte_idx_d   = byte_idx_q;
    wait_d       = wait_q;
    done_d       = done_q;
    dropped_d    = dropped_q;
    fmt_err_d    = fmt_err_q;
    sess_ok_d    = sess_ok_q;
    mono_ok_d    = mono_ok_q;
    crc_ok_d     = crc_ok_q;
    pass_d       = pass_q;
    hist_d       = hist_q;
    last_mono_d  = last_mono_q;
    locked_sid_d = locked_sid_q;
    crc_byte     = 8'h00;
    crc_feed     = 1'b0;
    crc_init     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_wr) begin
          done_d    = 1'b0;
          fmt_err_d = 1'b0;
          sess_ok_d = 1'b0;
          mono_ok_d = 1'b0;
          crc_ok_d  = 1'b0;
          pass_d    = 1'b0;
          if (ctrl_in[0]) begin
            sid_d     = ctrl_in[8:1];
            dropped_d = 1'b0;
            if (!rec_full_q || rec_pad != 8'h00) begin
              fmt_err_d = 1'b1;
              done_d    = 1'b1;
            end else begin
              crc_init   = 1'b1;
              byte_idx_d = 4'd0;
              // First FEED cycle acts as a wait so no feed follows crc_init directly
              wait_d     = 1'b1;
              state_d    = StFeed;
            end
          end else begin
            wr_seq_d   = 2'd0;
            rec_full_d = 1'b0;
          end
        end else if (rec_wr) begin
          case (wr_seq_q)
            2'd0: begin
              w0_d     = rec_in;
              wr_seq_d = 2'd1;
            end
            2'd1: begin
              w1_d     = rec_in;
              wr_seq_d = 2'd2;
            end
            2'd2: begin
              w2_d       = rec_in;
              wr_seq_d   = 2'd0;
              rec_full_d = 1'b1;
            end
            default: wr_seq_d = 2'd0;
          endcase
        end
      end

      StFeed: begin
        if (wait_q) begin
          if (!crc_busy) begin
            if (byte_idx_q == 4'd9) state_d = StCheck;
            else                    wait_d  = 1'b0;
          end
        end else if (!crc_busy) begin
          crc_feed = 1'b1;
          case (byte_idx_q)
            4'd0:    crc_byte = sid_q;
            4'd1:    crc_byte = w0_q[7:0];
            4'd2:    crc_byte = w0_q[15:8];
            4'd3:    crc_byte = w0_q[23:16];
            4'd4:    crc_byte = w0_q[31:24];
            4'd5:    crc_byte = rec_mono[7:0];
            4'd6:    crc_byte = rec_mono[15:8];
            4'd7:    crc_byte = rec_mono[23:16];
            4'd8:    crc_byte = rec_mono[31:24];
            default: crc_byte = 8'h00;
          endcase
          byte_idx_d = byte_idx_q + 4'd1;
          wait_d     = 1'b1;
        end
      end

      StCheck: begin
        if (!crc_busy) begin
          crc_ok_d   = chk_crc;
          mono_ok_d  = chk_mono;
          sess_ok_d  = chk_sess;
          pass_d     = chk_crc && chk_mono && chk_sess;
          done_d     = 1'b1;
          state_d    = StIdle;
          rec_full_d = 1'b0;
          wr_seq_d   = 2'd0;
          if (chk_crc && chk_mono && chk_sess) begin
            last_mono_d  = rec_mono;
            locked_sid_d = rec_sid;
            hist_d       = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A verify arriving mid-operation is lost; flag it
    if (busy && ctrl_wr && ctrl_in[0]) dropped_d = 1'b1;

    // Engine strobes drop immediately on reset, not at the next edge
    if (rst) begin
      crc_feed = 1'b0;
      crc_init = 1'b0;
    end
  end

  // State and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_seq_q     <= 2'd0;
      rec_full_q   <= 1'b0;
      w0_q         <= 32'h0;
      w1_q         <= 32'h0;
      w2_q         <= 32'h0;
      sid_q        <= 8'h00;
      byte_idx_q   <= 4'd0;
      wait_q       <= 1'b0;
      done_q       <= 1'b0;
      dropped_q    <= 1'b0;
      fmt_err_q    <= 1'b0;
      sess_ok_q    <= 1'b0;
      mono_ok_q    <= 1'b0;
      crc_ok_q     <= 1'b0;
      pass_q       <= 1'b0;
      hist_q       <= 1'b0;
      last_mono_q  <= 32'h0;
      locked_sid_q <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_seq_q     <= wr_seq_d;
      rec_full_q   <= rec_full_d;
      w0_q         <= w0_d;
      w1_q         <= w1_d;
      w2_q         <= w2_d;
      sid_q        <= sid_d;
      byte_idx_q   <= byte_idx_d;
      wait_q       <= wait_d;
      done_q       <= done_d;
      dropped_q    <= dropped_d;
      fmt_err_q    <= fmt_err_d;
      sess_ok_q    <= sess_ok_d;
      mono_ok_q    <= mono_ok_d;
      crc_ok_q     <= crc_ok_d;
      pass_q       <= pass_d;
      hist_q       <= hist_d;
      last_mono_q  <= last_mono_d;
      locked_sid_q <= locked_sid_d;
    end
  end

endmodule

// File: tb/tb_seal_verifier.sv
// Directed bench for seal_verifier with a behavioural CRC16 (0x1021, init 0xFFFF) engine.
module tb_seal_verifier;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  crc_byte;
  logic        crc_feed;
  logic        crc_busy;
  logic [15:0] crc_value;
  logic        crc_init;
  logic        rec_wr;
  logic [31:0] rec_in;
  logic        ctrl_wr;
  logic [8:0]  ctrl_in;
  logic [31:0] status_out;
  logic [31:0] last_mono_out;

  int compared   = 0;
  int mismatched = 0;

  seal_verifier dut (
    .clk           (clk),
    .rst           (rst),
    .crc_byte      (crc_byte),
    .crc_feed      (crc_feed),
    .crc_busy      (crc_busy),
    .crc_value     (crc_value),
    .crc_init      (crc_init),
    .rec_wr        (rec_wr),
    .rec_in        (rec_in),
    .ctrl_wr       (ctrl_wr),
    .ctrl_in       (ctrl_in),
    .status_out    (status_out),
    .last_mono_out (last_mono_out)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  function automatic logic [15:0] model_crc(input logic [7:0] sid, input logic [31:0] val,
                                            input logic [31:0] mono);
    logic [15:0] c;
    c = 16'hFFFF;
    c = crc_upd(c, sid);
    for (int i = 0; i < 4; i++) c = crc_upd(c, val[i*8 +: 8]);
    for (int i = 0; i < 4; i++) c = crc_upd(c, mono[i*8 +: 8]);
    return c;
  endfunction

  // Behavioural CRC engine: busy for eng_lat cycles after each consumed byte
  int          eng_lat = 0;
  int          eng_cnt = 0;
  logic [15:0] eng_crc = 16'h0;
  assign crc_busy  = (eng_cnt != 0);
  assign crc_value = eng_crc;

  always @(posedge clk) begin
    if (rst) begin
      eng_cnt <= 0;
    end else if (crc_init) begin
      eng_crc <= 16'hFFFF;
    end else if (crc_feed) begin
      eng_crc <= crc_upd(eng_crc, crc_byte);
      eng_cnt <= eng_lat;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Protocol monitor
  int   feed_total  = 0;
  int   init_total  = 0;
  int   proto_total = 0;
  logic init_prev   = 1'b0;
  always @(posedge clk) begin
    if (crc_feed) begin
      feed_total++;
      if (crc_busy || init_prev) proto_total++;
    end
    if (crc_init) init_total++;
    init_prev <= crc_init;
  end

  task automatic write_word(input logic [31:0] w);
    rec_wr = 1'b1;
    rec_in = w;
    @(negedge clk);
    rec_wr = 1'b0;
  endtask

  task automatic load_rec(input logic [7:0] vsid, input logic [7:0] rsid, input logic [31:0] mono,
                          input logic [31:0] val, input logic [7:0] pad, input logic [15:0] cx);
    logic [15:0] c;
    c = model_crc(vsid, val, mono) ^ cx;
    write_word(val);
    write_word({rsid, mono[23:0]});
    write_word({mono[31:24], c, pad});
  endtask

  // Pulse verify and wait for done; lat = cycles to done or -1 on timeout
  task automatic do_verify(input logic [7:0] sid, output int lat);
    lat = -1;
    ctrl_wr = 1'b1;
    ctrl_in = {sid, 1'b1};
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      ctrl_wr = 1'b0;
      if (status_out[8]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic verdict(input string name, input int lat, input logic [31:0] exp_st,
                         input logic [31:0] exp_mono, input int exp_feeds, input int feeds,
                         input int protos);
    compared++;
    if (lat < 0) begin
      mismatched++;
      $display("FAIL %s timeout: no done within budget", name);
    end
    compared++;
    if (status_out !== exp_st) begin
      mismatched++;
      $display("FAIL %s status: got %h want %h", name, status_out, exp_st);
    end
    compared++;
    if (last_mono_out !== exp_mono) begin
      mismatched++;
      $display("FAIL %s last_mono: got %h want %h", name, last_mono_out, exp_mono);
    end
    compared++;
    if (feeds !== exp_feeds) begin
      mismatched++;
      $display("FAIL %s feed count: got %0d want %0d", name, feeds, exp_feeds);
    end
    compared++;
    if (protos !== 0) begin
      mismatched++;
      $display("FAIL %s handshake violations: got %0d want 0", name, protos);
    end
  endtask

  task automatic run_case(input string name, input logic [7:0] sid, input logic [31:0] exp_st,
                          input logic [31:0] exp_mono, input int exp_feeds);
    int lat, f0, p0;
    f0 = feed_total;
    p0 = proto_total;
    do_verify(sid, lat);
    verdict(name, lat, exp_st, exp_mono, exp_feeds, feed_total - f0, proto_total - p0);
  endtask

  task automatic test_reset();
    compared++;
    if (status_out !== 32'h2 || last_mono_out !== 32'h0) begin
      mismatched++;
      $display("FAIL reset: status %h mono %h want 00000002 00000000", status_out, last_mono_out);
    end
    compared++;
    if (crc_feed !== 1'b0 || crc_init !== 1'b0) begin
      mismatched++;
      $display("FAIL reset strobes: feed %b init %b want 0 0", crc_feed, crc_init);
    end
  endtask

  task automatic test_pass_latency();
    int lat, f0, i0, p0;
    eng_lat = 0;
    load_rec(8'h03, 8'h5A, 32'h0, 32'h12345678, 8'h00, 16'h0);
    f0 = feed_total;
    i0 = init_total;
    p0 = proto_total;
    do_verify(8'h03, lat);
    verdict("first_pass", lat, 32'h13E, 32'h0, 9, feed_total - f0, proto_total - p0);
    compared++;
    if (lat !== 21) begin
      mismatched++;
      $display("FAIL latency: got %0d want 21", lat);
    end
    compared++;
    if (init_total - i0 !== 1) begin
      mismatched++;
      $display("FAIL crc_init count: got %0d want 1", init_total - i0);
    end
  endtask

  task automatic test_replay();
    load_rec(8'h03, 8'h5A, 32'h0, 32'h12345678, 8'h00, 16'h0);
    run_case("replay", 8'h03, 32'h12A, 32'h0, 9);
  endtask

  task automatic test_crc_and_mono();
    eng_lat = 2;
    load_rec(8'h03, 8'h5A, 32'h1, 32'hCAFEF00D, 8'h00, 16'h0001);
    run_case("bad_crc", 8'h03, 32'h132, 32'h0, 9);
    load_rec(8'h03, 8'h5A, 32'h1, 32'hCAFEF00D, 8'h00, 16'h0);
    run_case("mono1_pass", 8'h03, 32'h13E, 32'h1, 9);
  endtask

  task automatic test_session_and_fmt();
    int i0;
    load_rec(8'h03, 8'h5B, 32'h2, 32'h0BADBEEF, 8'h00, 16'h0);
    run_case("bad_session", 8'h03, 32'h11A, 32'h1, 9);
    i0 = init_total;
    load_rec(8'h03, 8'h5A, 32'h2, 32'h0BADBEEF, 8'h01, 16'h0);
    run_case("bad_pad", 8'h03, 32'h142, 32'h1, 0);
    compared++;
    if (init_total - i0 !== 0) begin
      mismatched++;
      $display("FAIL bad_pad crc_init count: got %0d want 0", init_total - i0);
    end
  endtask

  task automatic test_back_to_back();
    int lat, f0, p0;
    eng_lat = 1;
    load_rec(8'h07, 8'h5A, 32'h2, 32'h00C0FFEE, 8'h00, 16'h0);
    f0 = feed_total;
    p0 = proto_total;
    ctrl_wr = 1'b1;
    ctrl_in = {8'h07, 1'b1};
    @(negedge clk);
    ctrl_wr = 1'b0;
    repeat (4) @(negedge clk);
    ctrl_wr = 1'b1;
    ctrl_in = {8'h99, 1'b1};
    @(negedge clk);
    ctrl_wr = 1'b0;
    compared++;
    if (status_out !== 32'h81) begin
      mismatched++;
      $display("FAIL dropped while busy: status %h want 00000081", status_out);
    end
    lat = -1;
    for (int n = 1; n <= 400; n++) begin
      if (status_out[8]) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    verdict("dropped_verdict", lat, 32'h1BE, 32'h2, 9, feed_total - f0, proto_total - p0);
    load_rec(8'h07, 8'h5A, 32'h3, 32'h00C0FFEE, 8'h00, 16'h0);
    run_case("dropped_clear", 8'h07, 32'h13E, 32'h3, 9);
  endtask

  task automatic test_reset_mid_feed();
    int lat;
    eng_lat = 0;
    load_rec(8'h03, 8'h5A, 32'h5, 32'h11111111, 8'h00, 16'h0);
    ctrl_wr = 1'b1;
    ctrl_in = {8'h03, 1'b1};
    @(negedge clk);
    ctrl_wr = 1'b0;
    lat = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (crc_feed && n > 3) begin
        lat = n;
        break;
      end
    end
    compared++;
    if (lat < 0) begin
      mismatched++;
      $display("FAIL mid_feed: no crc_feed observed");
    end
    rst = 1'b1;
    #1;
    compared++;
    if (crc_feed !== 1'b0 || crc_init !== 1'b0 || status_out !== 32'h2 ||
        last_mono_out !== 32'h0) begin
      mismatched++;
      $display("FAIL async reset: feed %b init %b status %h mono %h want 0 0 00000002 00000000",
               crc_feed, crc_init, status_out, last_mono_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_rec(8'h03, 8'h44, 32'h0, 32'h22222222, 8'h00, 16'h0);
    run_case("post_reset_mono0", 8'h03, 32'h13E, 32'h0, 9);
  endtask

  task automatic test_mono_max_and_clear();
    load_rec(8'h03, 8'h44, 32'hFFFFFFFF, 32'h33333333, 8'h00, 16'h0);
    run_case("mono_max", 8'h03, 32'h13E, 32'hFFFFFFFF, 9);
    load_rec(8'h03, 8'h44, 32'hFFFFFFFF, 32'h44444444, 8'h00, 16'h0);
    run_case("after_max", 8'h03, 32'h12A, 32'hFFFFFFFF, 9);
    ctrl_wr = 1'b1;
    ctrl_in = 9'h000;
    @(negedge clk);
    ctrl_wr = 1'b0;
    compared++;
    if (status_out !== 32'h2 || last_mono_out !== 32'hFFFFFFFF) begin
      mismatched++;
      $display("FAIL clear: status %h mono %h want 00000002 ffffffff", status_out, last_mono_out);
    end
    // Clear also empties the record buffer, so verify now reports a format error
    run_case("verify_after_clear", 8'h03, 32'h142, 32'hFFFFFFFF, 0);
  endtask

  initial begin
    rst     = 1'b1;
    rec_wr  = 1'b0;
    rec_in  = 32'h0;
    ctrl_wr = 1'b0;
    ctrl_in = 9'h0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_pass_latency();
    test_replay();
    test_crc_and_mono();
    test_session_and_fmt();
    test_back_to_back();
    test_reset_mid_feed();
    test_mono_max_and_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
